// File: rtl/reset_seq_ctrl.sv
// Staged reset-release sequencer: qualifies PLL lock/init, releases NUM_STAGES domains in order,
// re-asserts on fault with SS/Flash*Freeze deferral. Optional RESET_SEQ_REVERSE_ASSERT_EN drains stages top-down.
module reset_seq_ctrl #(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DLY   = 16,
  parameter int LOCK_FILTER = 8
) (
  input  logic                  CLK,
  input  logic                  EXT_RST_N,
  input  logic                  PLL_LOCK,
  input  logic                  INIT_DONE,
  input  logic                  SS_BUSY,
  input  logic                  FF_US_RESTORE,
  input  logic                  SW_RST_REQ,
  output logic [NUM_STAGES-1:0] STAGE_RST_N,
  output logic                  SEQ_DONE,
  output logic [2:0]            SEQ_STATE
);

  localparam int FW = $clog2(LOCK_FILTER) + 1;
  localparam int DW = $clog2(STAGE_DLY) + 1;
  localparam int IW = $clog2(NUM_STAGES) + 1;

  localparam logic [FW-1:0] FILT_TC = FW'(LOCK_FILTER - 1);
  localparam logic [DW-1:0] DLY_TC  = DW'(STAGE_DLY - 1);
  localparam logic [IW-1:0] IDX_END = IW'(NUM_STAGES);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_RELEASE   = 3'd1,
    S_RUN       = 3'd2,
    S_HOLD      = 3'd3,
    S_ASSERT    = 3'd4,
    S_DRAIN     = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [FW-1:0]           filt_q, filt_d;
  logic [DW-1:0]           dly_q, dly_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [NUM_STAGES-1:0]   stage_q, stage_d;
  logic                    done_q, done_d;
  logic                    pend_q, pend_d;

  logic good, fault, gate, fire;

  assign good  = PLL_LOCK & INIT_DONE;
  assign fault = !good | SW_RST_REQ;
  assign gate  = SS_BUSY | FF_US_RESTORE;

  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    dly_d   = dly_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    done_d  = done_q;
    pend_d  = pend_q;
    fire    = 1'b0;

    case (state_q)
      S_WAIT_LOCK: begin
        pend_d = 1'b0;
        if (!good) begin
          filt_d = '0;
        end else if (filt_q == FILT_TC) begin
          state_d = S_RELEASE;
          filt_d  = '0;
          dly_d   = '0;
          idx_d   = '0;
        end else begin
          filt_d = filt_q + 1'b1;
        end
      end

      S_RELEASE: begin
        // Fault takes priority over a terminal-count stage release.
        if (fault) begin
          if (gate) begin
            state_d = S_HOLD;
            pend_d  = 1'b1;
          end else begin
            fire = 1'b1;
          end
        end else if (idx_q == IDX_END) begin
          state_d = S_RUN;
          done_d  = 1'b1;
        end else if (dly_q == DLY_TC) begin
          for (int k = 0; k < NUM_STAGES; k++)
            if (idx_q == IW'(k)) stage_d[k] = 1'b1;
          idx_d = idx_q + 1'b1;
          dly_d = '0;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end

      S_RUN: begin
        if (fault) begin
          if (gate) begin
            state_d = S_HOLD;
            pend_d  = 1'b1;
          end else begin
            fire = 1'b1;
          end
        end
      end

      S_HOLD: begin
        // Pending fault is sticky: only the gate dropping lets it through.
        if (pend_q && !gate) fire = 1'b1;
      end

      S_ASSERT: begin
        state_d = S_WAIT_LOCK;
        filt_d  = '0;
      end

`ifdef RESET_SEQ_REVERSE_ASSERT_EN
      S_DRAIN: begin
        if (dly_q == DLY_TC) begin
          dly_d = '0;
          for (int k = 0; k < NUM_STAGES; k++)
            if (idx_q == IW'(k + 1)) stage_d[k] = 1'b0;
          idx_d = idx_q - 1'b1;
          if (idx_q == IW'(1)) begin
            state_d = S_WAIT_LOCK;
            filt_d  = '0;
          end
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
`endif

      default: begin
        state_d = S_WAIT_LOCK;
        filt_d  = '0;
      end
    endcase

    if (fire) begin
      pend_d = 1'b0;
      done_d = 1'b0;
      filt_d = '0;
      dly_d  = '0;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
      // idx tracks how many low bits still remain to be drained.
      stage_d[NUM_STAGES-1] = 1'b0;
      idx_d = IW'(NUM_STAGES - 1);
      if (NUM_STAGES == 1) state_d = S_WAIT_LOCK;
      else                 state_d = S_DRAIN;
`else
      stage_d = '0;
      state_d = S_ASSERT;
`endif
    end
  end

  always_ff @(posedge CLK or negedge EXT_RST_N) begin
    if (!EXT_RST_N) begin
      state_q <= S_WAIT_LOCK;
      filt_q  <= '0;
      dly_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      dly_q   <= dly_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  assign STAGE_RST_N = stage_q;
  assign SEQ_DONE    = done_q;
  assign SEQ_STATE   = state_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl with default parameters (4 stages, 16-cycle spacing, 8-cycle filter).
module tb_reset_seq_ctrl;

  logic       CLK = 1'b0;
  logic       EXT_RST_N, PLL_LOCK, INIT_DONE, SS_BUSY, FF_US_RESTORE, SW_RST_REQ;
  logic [3:0] STAGE_RST_N;
  logic       SEQ_DONE;
  logic [2:0] SEQ_STATE;

  int total = 0;
  int bad   = 0;

  reset_seq_ctrl dut (
    .CLK(CLK), .EXT_RST_N(EXT_RST_N), .PLL_LOCK(PLL_LOCK), .INIT_DONE(INIT_DONE),
    .SS_BUSY(SS_BUSY), .FF_US_RESTORE(FF_US_RESTORE), .SW_RST_REQ(SW_RST_REQ),
    .STAGE_RST_N(STAGE_RST_N), .SEQ_DONE(SEQ_DONE), .SEQ_STATE(SEQ_STATE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic apply_rst();
    EXT_RST_N = 1'b0;
    tick(5);
    chk("rst_stage", STAGE_RST_N, 4'b0000);
    chk("rst_done",  SEQ_DONE,    1'b0);
    chk("rst_state", SEQ_STATE,   3'd0);
    EXT_RST_N = 1'b1;
  endtask

  // Expects WAIT_LOCK with a cleared filter and good=1; walks the whole release.
  task automatic run_seq(input string t);
    tick(7);
    chk({t, "_pre_rel"}, SEQ_STATE, 3'd0);
    tick(1);
    chk({t, "_rel"},     SEQ_STATE, 3'd1);
    tick(15);
    chk({t, "_s15"},     STAGE_RST_N, 4'b0000);
    tick(1);
    chk({t, "_s16"},     STAGE_RST_N, 4'b0001);
    tick(16);
    chk({t, "_s32"},     STAGE_RST_N, 4'b0011);
    tick(16);
    chk({t, "_s48"},     STAGE_RST_N, 4'b0111);
    tick(16);
    chk({t, "_s64"},     STAGE_RST_N, 4'b1111);
    chk({t, "_d64"},     SEQ_DONE,    1'b0);
    tick(1);
    chk({t, "_d65"},     SEQ_DONE,    1'b1);
    chk({t, "_run"},     SEQ_STATE,   3'd2);
  endtask

  // Called right after the edge on which the reset was re-asserted; ends on WAIT_LOCK entry.
  task automatic expect_clear(input string t);
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
    chk({t, "_drain"},   SEQ_STATE,   3'd5);
    chk({t, "_d0"},      STAGE_RST_N, 4'b0111);
    chk({t, "_done0"},   SEQ_DONE,    1'b0);
    tick(15);
    chk({t, "_d15"},     STAGE_RST_N, 4'b0111);
    tick(1);
    chk({t, "_d16"},     STAGE_RST_N, 4'b0011);
    tick(16);
    chk({t, "_d32"},     STAGE_RST_N, 4'b0001);
    tick(16);
    chk({t, "_d48"},     STAGE_RST_N, 4'b0000);
    chk({t, "_wait"},    SEQ_STATE,   3'd0);
`else
    chk({t, "_assert"},  SEQ_STATE,   3'd4);
    chk({t, "_clr"},     STAGE_RST_N, 4'b0000);
    chk({t, "_done0"},   SEQ_DONE,    1'b0);
    tick(1);
    chk({t, "_wait"},    SEQ_STATE,   3'd0);
`endif
  endtask

  initial begin
    EXT_RST_N = 1'b0; PLL_LOCK = 1'b1; INIT_DONE = 1'b1;
    SS_BUSY = 1'b0; FF_US_RESTORE = 1'b0; SW_RST_REQ = 1'b0;

    // Power-up sequence
    apply_rst();
    run_seq("pwr");

    // Ungated fault: INIT_DONE drop in RUN
    INIT_DONE = 1'b0;
    tick(1);
    INIT_DONE = 1'b1;
    expect_clear("init");
    run_seq("init_rs");

    // Lock loss deferred by SS_BUSY
    SS_BUSY = 1'b1;
    PLL_LOCK = 1'b0;
    tick(1);
    chk("busy_hold",  SEQ_STATE,   3'd3);
    chk("busy_stage", STAGE_RST_N, 4'b1111);
    tick(3);
    PLL_LOCK = 1'b1;
    tick(2);
    chk("busy_sticky", SEQ_STATE,  3'd3);
    chk("busy_done",   SEQ_DONE,   1'b1);
    SS_BUSY = 1'b0;
    tick(1);
    expect_clear("busy");
    run_seq("busy_rs");

    // Soft reset deferred by Flash*Freeze restore; a second request is absorbed
    FF_US_RESTORE = 1'b1;
    SW_RST_REQ = 1'b1;
    tick(1);
    SW_RST_REQ = 1'b0;
    chk("ff_hold", SEQ_STATE, 3'd3);
    tick(2);
    SW_RST_REQ = 1'b1;
    tick(1);
    SW_RST_REQ = 1'b0;
    chk("ff_hold2",  SEQ_STATE,   3'd3);
    chk("ff_stage",  STAGE_RST_N, 4'b1111);
    tick(2);
    FF_US_RESTORE = 1'b0;
    tick(1);
    expect_clear("ff");
    run_seq("ff_rs");

    // Fault coincident with a terminal count: stage 0 must not be released
    apply_rst();
    tick(8);
    chk("tc_rel", SEQ_STATE, 3'd1);
    tick(15);
    PLL_LOCK = 1'b0;
    tick(1);
    PLL_LOCK = 1'b1;
    chk("tc_stage", STAGE_RST_N, 4'b0000);
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
    chk("tc_state", SEQ_STATE, 3'd5);
`else
    chk("tc_state", SEQ_STATE, 3'd4);
`endif

    // Lock glitch on the 5th filter cycle restarts the filter
    apply_rst();
    tick(4);
    PLL_LOCK = 1'b0;
    tick(1);
    chk("glitch_wait", SEQ_STATE, 3'd0);
    PLL_LOCK = 1'b1;
    tick(7);
    chk("glitch_pre", SEQ_STATE, 3'd0);
    tick(1);
    chk("glitch_rel", SEQ_STATE, 3'd1);

    // Asynchronous reset mid-release
    tick(32);
    chk("mid_stage", STAGE_RST_N, 4'b0011);
    tick(5);
    #2 EXT_RST_N = 1'b0;
    #1;
    chk("async_stage", STAGE_RST_N, 4'b0000);
    chk("async_state", SEQ_STATE,   3'd0);
    chk("async_done",  SEQ_DONE,    1'b0);
    tick(2);
    EXT_RST_N = 1'b1;
    run_seq("post_async");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reset_seq_ctrl.md
Name: reset_seq_ctrl

Overview:
- Staged reset-release sequencer that sits downstream of the fabric reset synchroniser.
- Qualifies PLL lock and device init, then releases NUM_STAGES downstream reset domains one after another with a fixed cycle spacing.
- Re-asserts reset on lock loss, init loss or a software request, deferring assertion while the system controller is busy or a Flash*Freeze restore is in progress.

Parameters:
- NUM_STAGES, 4: number of sequenced reset domains (1..8).
- STAGE_DLY, 16: cycles between successive stage releases (>=2).
- LOCK_FILTER, 8: consecutive cycles PLL_LOCK=1 and INIT_DONE=1 required before sequencing starts (>=1).

Ports:
- CLK  in  1  system clock.
- EXT_RST_N  in  1  asynchronous, active-low reset.
- PLL_LOCK  in  1  PLL lock status (synchronous to CLK).
- INIT_DONE  in  1  device initialisation complete.
- SS_BUSY  in  1  system controller busy; defers reset assertion.
- FF_US_RESTORE  in  1  Flash*Freeze user-state restore active; defers reset assertion.
- SW_RST_REQ  in  1  single-cycle soft reset request.
- STAGE_RST_N  out  NUM_STAGES  per-domain active-low resets; bit 0 is released first.
- SEQ_DONE  out  1  all stages released.
- SEQ_STATE  out  3  current FSM state (debug).

Behaviour:
- Clocking and reset: one clock, CLK. EXT_RST_N is asynchronous and active-low.
- Reset values: STAGE_RST_N=0, SEQ_DONE=0, SEQ_STATE=WAIT_LOCK (0), all counters 0, pending flag 0.
- Outputs: all registered.
- good = PLL_LOCK & INIT_DONE.
- fault = !good | SW_RST_REQ.
- gate = SS_BUSY | FF_US_RESTORE.
- State encoding: WAIT_LOCK=0, RELEASE=1, RUN=2, HOLD=3, ASSERT=4, DRAIN=5.
- WAIT_LOCK:
  - Filter counter increments each cycle good=1 and clears when good=0.
  - On the edge where the 8th consecutive good cycle is seen (count==LOCK_FILTER-1), go to RELEASE with delay counter=0 and stage index=0.
- RELEASE:
  - Delay counter counts 0..STAGE_DLY-1.
  - At terminal count, set STAGE_RST_N[index], increment index, clear the counter.
  - Stage k rises exactly (k+1)*STAGE_DLY cycles after RELEASE entry.
  - After the last stage, go to RUN. SEQ_DONE rises on the edge entering RUN, one cycle after the last stage bit.
- RUN: outputs steady.
- Fault handling in RELEASE or RUN:
  - fault with gate=0: go to ASSERT and clear STAGE_RST_N and SEQ_DONE on the same edge.
  - fault with gate=1: go to HOLD; outputs unchanged.
- HOLD:
  - The pending fault is sticky; it is not cancelled if good returns.
  - Stays in HOLD while gate=1.
  - First cycle with gate=0: go to ASSERT with outputs cleared on that edge.
- ASSERT: lasts exactly 1 cycle, then WAIT_LOCK with the filter counter cleared.
- SW_RST_REQ is ignored in WAIT_LOCK, ASSERT and HOLD (already resetting or pending).
- Simultaneous events:
  - fault on the same edge as a RELEASE terminal count: fault wins and the stage is not released.
  - gate rising on the same edge as a fault: HOLD.
- EXT_RST_N low at any time, including mid-RELEASE: all outputs go to reset values immediately (asynchronously).
- Counter widths: $clog2 of the max value plus 1. No wrap; counters are cleared explicitly.

Optional Feature:
- Macro: RESET_SEQ_REVERSE_ASSERT_EN.
- Defined:
  - The ASSERT condition enters DRAIN instead of ASSERT.
  - SEQ_DONE clears on that edge, and STAGE_RST_N[NUM_STAGES-1] clears on the same edge.
  - Each subsequent STAGE_DLY cycles clears the next lower bit.
  - After bit 0 clears, go to WAIT_LOCK.
  - EXT_RST_N still clears all bits immediately.
- Undefined: all stages clear simultaneously via ASSERT; state 5 is unreachable.

Test Plan:
1. Power-up with defaults: EXT_RST_N low 5 cycles then high; PLL_LOCK=INIT_DONE=1, gate=0.
   -> RELEASE entered on the 8th good cycle.
   -> STAGE_RST_N=4'b0001 at +16 cycles, 4'b0011 at +32, 4'b0111 at +48, 4'b1111 at +64.
   -> SEQ_DONE=1 at +65.
2. PLL_LOCK low for 1 cycle on the 5th filter cycle.
   -> Filter restarts; RELEASE entry delayed to 8 cycles after PLL_LOCK returns high.
3. In RUN with SS_BUSY=1, drop PLL_LOCK.
   -> SEQ_STATE=3 and STAGE_RST_N stays 4'b1111.
   -> Restore PLL_LOCK, then drop SS_BUSY: ASSERT on the next edge with STAGE_RST_N=0 and SEQ_DONE=0, then WAIT_LOCK and the full re-sequence per scenario 1.
4. In RUN with FF_US_RESTORE=1, pulse SW_RST_REQ.
   -> HOLD until FF_US_RESTORE=0, then ASSERT.
   -> A second SW_RST_REQ during HOLD has no extra effect.
5. EXT_RST_N pulsed low mid-RELEASE with STAGE_RST_N=4'b0011.
   -> STAGE_RST_N=0 asynchronously, before the next CLK edge; SEQ_STATE=0.
6. With RESET_SEQ_REVERSE_ASSERT_EN defined, drop INIT_DONE in RUN with gate=0.
   -> STAGE_RST_N=4'b0111, then 4'b0011 at +16, 4'b0001 at +32, 4'b0000 at +48.
   -> Then WAIT_LOCK.
